// File: rtl/uart_cmd_parser.sv
// Frame parser behind the car controller UART: assembles A5/CMD/PARAM/SUM/5A frames,
// checks sum, tail and inter-byte timing. Optional link watchdog under `CMD_WDOG_EN.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter logic [7:0] TAIL        = 8'h5A,
    parameter int         TIMEOUT     = 1250000,
    parameter int         WDOG_CYCLES = 62500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic [7:0] param,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_cnt,
    output logic       wdog_stop,
    output logic [2:0] dbg_state
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_CMD   = 3'd1,
        S_GET_PARAM = 3'd2,
        S_GET_SUM   = 3'd3,
        S_GET_TAIL  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_cmd;
    logic [7:0]      r_param;
    logic [7:0]      r_cmd_out;
    logic [7:0]      r_param_out;
    logic            r_cmd_valid;
    logic            r_frame_err;
    logic            r_busy;
    logic [7:0]      r_err_cnt;
    logic [7:0]      w_sum;
    logic            w_timeout;
    logic            w_err;
    logic            w_accept;
    logic            w_ld_cmd;
    logic            w_ld_param;

    assign w_sum     = r_cmd + r_param;
    // An rx_flag in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !rx_flag && (r_timer == TW'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_accept   = 1'b0;
        w_ld_cmd   = 1'b0;
        w_ld_param = 1'b0;
        if (rx_flag) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == HEADER) w_next = S_GET_CMD;
                end
                S_GET_CMD: begin
                    w_ld_cmd = 1'b1;
                    w_next   = S_GET_PARAM;
                end
                S_GET_PARAM: begin
                    w_ld_param = 1'b1;
                    w_next     = S_GET_SUM;
                end
                S_GET_SUM: begin
                    if (rx_data == w_sum) begin
                        w_next = S_GET_TAIL;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end
                S_GET_TAIL: begin
                    if (rx_data == TAIL) w_accept = 1'b1;
                    else                 w_err    = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_cmd       <= 8'h00;
            r_param     <= 8'h00;
            r_cmd_out   <= 8'h00;
            r_param_out <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_err_cnt   <= 8'h00;
        end else begin
            r_state     <= w_next;
            r_cmd_valid <= w_accept;
            r_frame_err <= w_err;
            r_busy      <= (w_next != S_IDLE);
            if (r_state == S_IDLE || rx_flag) r_timer <= '0;
            else                              r_timer <= r_timer + TW'(1);
            if (w_ld_cmd)   r_cmd   <= rx_data;
            if (w_ld_param) r_param <= rx_data;
            if (w_accept) begin
                r_cmd_out   <= r_cmd;
                r_param_out <= r_param;
            end
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef CMD_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

    logic [WW-1:0] r_wdog;
    logic          r_wdog_stop;

    // Cleared on the same edge that raises cmd_valid, so stop drops with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog      <= '0;
            r_wdog_stop <= 1'b0;
        end else if (w_accept) begin
            r_wdog      <= '0;
            r_wdog_stop <= 1'b0;
        end else if (r_wdog == WW'(WDOG_CYCLES - 1)) begin
            r_wdog_stop <= 1'b1;
        end else begin
            r_wdog <= r_wdog + WW'(1);
        end
    end

    assign wdog_stop = r_wdog_stop;
`else
    assign wdog_stop = 1'b0;
`endif

    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd_out;
    assign param     = r_param_out;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frames, checksum wrap, errors, timeout, reset, saturation.
module tb_uart_cmd_parser;

    localparam int TO = 100;
    localparam int WD = 1000;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic [7:0] param;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_cnt;
    logic       wdog_stop;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    uart_cmd_parser #(
        .HEADER(8'hA5), .TAIL(8'h5A), .TIMEOUT(TO), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
        .cmd_valid(cmd_valid), .cmd(cmd), .param(param), .frame_err(frame_err),
        .busy(busy), .err_cnt(err_cnt), .wdog_stop(wdog_stop), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is sampled on the next rising edge; returns 1 ns after that edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(posedge clk); #1;
        rx_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] p, input logic [7:0] s,
                              input logic [7:0] t);
        send_byte(8'hA5); idle(1);
        send_byte(c);     idle(1);
        send_byte(p);     idle(1);
        send_byte(s);     idle(1);
        send_byte(t);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        #3;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_param", param, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_wdog_stop", wdog_stop, 0);
        check("rst_state", dbg_state, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_flag = 1'b0;
        rx_data = 8'h00;
        idle(1);
        do_reset();

        // Basic frame
        send_byte(8'hA5);
        @(negedge clk);
        check("busy_after_hdr", busy, 1);
        idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h64); idle(1);
        send_byte(8'h65); idle(1);
        send_byte(8'h5A);
        @(negedge clk);
        check("f1_valid", cmd_valid, 1);
        check("f1_cmd", cmd, 8'h01);
        check("f1_param", param, 8'h64);
        check("f1_err", frame_err, 0);
        check("f1_errcnt", err_cnt, 0);
        check("f1_busy", busy, 0);
        @(negedge clk);
        check("f1_valid_1clk", cmd_valid, 0);
        check("f1_cmd_held", cmd, 8'h01);

        // Checksum wrap
        idle(1);
        send_frame(8'hFF, 8'h02, 8'h01, 8'h5A);
        @(negedge clk);
        check("f2_valid", cmd_valid, 1);
        check("f2_cmd", cmd, 8'hFF);
        check("f2_param", param, 8'h02);

        // Bad checksum, trailing tail ignored
        idle(1);
        send_byte(8'hA5); idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h64); idle(1);
        send_byte(8'h66);
        @(negedge clk);
        check("bs_err", frame_err, 1);
        check("bs_errcnt", err_cnt, 1);
        check("bs_busy", busy, 0);
        check("bs_valid", cmd_valid, 0);
        idle(1);
        send_byte(8'h5A);
        @(negedge clk);
        check("bs_tail_valid", cmd_valid, 0);
        check("bs_tail_err", frame_err, 0);
        check("bs_tail_errcnt", err_cnt, 1);
        check("bs_cmd_kept", cmd, 8'hFF);
        check("bs_param_kept", param, 8'h02);

        // Timeout
        idle(1);
        send_byte(8'hA5); idle(1);
        send_byte(8'h01);
        idle(TO - 1);
        @(negedge clk);
        check("to_pre_err", frame_err, 0);
        check("to_pre_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_err", frame_err, 1);
        check("to_busy", busy, 0);
        check("to_errcnt", err_cnt, 2);
        check("to_state", dbg_state, 0);

        // Bytes arriving exactly in the expiry cycle
        idle(1);
        send_byte(8'hA5); idle(1);
        send_byte(8'h01);
        idle(TO - 1);
        send_byte(8'h64);
        @(negedge clk);
        check("exp_err", frame_err, 0);
        check("exp_busy", busy, 1);
        idle(TO - 1);
        send_byte(8'h65); idle(1);
        send_byte(8'h5A);
        @(negedge clk);
        check("exp_valid", cmd_valid, 1);
        check("exp_cmd", cmd, 8'h01);
        check("exp_param", param, 8'h64);
        check("exp_errcnt", err_cnt, 2);

        // Junk in IDLE, then a frame
        idle(1);
        send_byte(8'h00);
        @(negedge clk);
        check("junk0_err", frame_err, 0);
        check("junk0_busy", busy, 0);
        idle(1);
        send_byte(8'h33);
        @(negedge clk);
        check("junk1_err", frame_err, 0);
        check("junk_errcnt", err_cnt, 2);
        idle(1);
        send_frame(8'h02, 8'h10, 8'h12, 8'h5A);
        @(negedge clk);
        check("f3_valid", cmd_valid, 1);
        check("f3_cmd", cmd, 8'h02);
        check("f3_param", param, 8'h10);

        // Bad tail equal to HEADER: no resync; next frame back-to-back
        idle(1);
        send_frame(8'h03, 8'h04, 8'h07, 8'hA5);
        @(negedge clk);
        check("bt_err", frame_err, 1);
        check("bt_busy", busy, 0);
        check("bt_errcnt", err_cnt, 3);
        check("bt_valid", cmd_valid, 0);
        send_frame(8'h05, 8'h06, 8'h0B, 8'h5A);
        send_frame(8'h07, 8'h08, 8'h0F, 8'h5A);
        @(negedge clk);
        check("b2b_valid", cmd_valid, 1);
        check("b2b_cmd", cmd, 8'h07);
        check("b2b_param", param, 8'h08);

        // Reset mid-frame
        idle(1);
        send_byte(8'hA5); idle(1);
        send_byte(8'h03);
        do_reset();
        send_byte(8'h04); idle(1);
        send_byte(8'h07); idle(1);
        send_byte(8'h5A);
        @(negedge clk);
        check("post_rst_valid", cmd_valid, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_errcnt", err_cnt, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            idle(1);
            send_byte(8'hA5); idle(1);
            send_byte(8'h00); idle(1);
            send_byte(8'h00); idle(1);
            send_byte(8'h01);
        end
        @(negedge clk);
        check("sat_err_pulse", frame_err, 1);
        check("sat_errcnt", err_cnt, 8'hFF);

        // Watchdog
        do_reset();
`ifdef CMD_WDOG_EN
        idle(WD - 20);
        check("wd_early", wdog_stop, 0);
        idle(40);
        check("wd_set", wdog_stop, 1);
        send_frame(8'h09, 8'h01, 8'h0A, 8'h5A);
        @(negedge clk);
        check("wd_valid", cmd_valid, 1);
        check("wd_clear", wdog_stop, 0);
`else
        idle(WD + 100);
        check("wd_off", wdog_stop, 0);
        send_frame(8'h09, 8'h01, 8'h0A, 8'h5A);
        @(negedge clk);
        check("wd_off_valid", cmd_valid, 1);
        check("wd_off_stop", wdog_stop, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
